// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter that lets 2..4 Wishbone B4 classic masters share one slave.
// Defining ARB_TIMEOUT_EN adds a stall watchdog that errors and releases a hung cycle.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_w,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [DATA_W-1:0]               m_dat_r,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_adr,
  output logic [DATA_W-1:0]               s_dat_w,
  output logic [DATA_W/8-1:0]             s_sel,
  input  logic                            s_ack,
  input  logic                            s_err,
  input  logic [DATA_W-1:0]               s_dat_r,
  output logic [NUM_MASTERS-1:0]          grant
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int SEL_W = DATA_W / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..4 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       last_q;
  logic                   owned;
  logic                   timeout_hit;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;

  logic [ADDR_W-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_W-1:0] dat_arr [NUM_MASTERS];
  logic [SEL_W-1:0]  sel_arr [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign adr_arr[gi] = m_adr[gi*ADDR_W +: ADDR_W];
    assign dat_arr[gi] = m_dat_w[gi*DATA_W +: DATA_W];
    assign sel_arr[gi] = m_sel[gi*SEL_W +: SEL_W];
  end

  assign owned = (state_q == OWNED);

  // Search starts one past the previous owner, so the last winner has lowest priority.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_MASTERS);
      if (!pick_found && m_cyc[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= OWNED;
            grant_q <= pick_oh;
            idx_q   <= pick_idx;
          end
        end
        OWNED: begin
          if (!m_cyc[idx_q] || timeout_hit) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= idx_q;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout_hit = owned && (cnt_q == CNT_W'(TIMEOUT));

  // Counts only stalled strobes; any slave response restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!owned || timeout_hit || s_ack || s_err) begin
      cnt_q <= '0;
    end else if (s_stb) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign grant   = grant_q;
  assign s_cyc   = owned & m_cyc[idx_q] & ~timeout_hit;
  assign s_stb   = owned & m_stb[idx_q] & ~timeout_hit;
  assign s_we    = owned & m_we[idx_q];
  assign s_adr   = adr_arr[idx_q];
  assign s_dat_w = dat_arr[idx_q];
  assign s_sel   = sel_arr[idx_q];
  assign m_dat_r = s_dat_r;
  // grant_q is all-zero in IDLE, which also masks the responses there.
  assign m_ack   = grant_q & {NUM_MASTERS{s_ack}};
  assign m_err   = (grant_q & {NUM_MASTERS{s_err}}) | (timeout_hit ? grant_q : '0);

endmodule
